// File: rtl/addsub_pkg.sv
// addsub_pkg -- shared definitions for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the in_op port.
//   addsub_flags_t  : status flags that travel with each result.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;  // carry-out on add, borrow-out on subtract
    logic ovf;   // signed overflow
    logic zero;  // final result == 0
    logic neg;   // final result MSB
  } addsub_flags_t;

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice -- one combinational slice of the carry chain.
//   a_i, b_i : slice operands (b already conditioned by the caller)
//   c_i      : carry into the slice
//   s_o      : slice sum
//   c_o      : carry out of the slice
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub -- STAGES-deep pipelined adder/subtractor with valid/ready
// handshakes on both sides.
//   clk, rst_n             : clock (rising edge), async active-low reset
//   in_valid / in_ready    : input handshake
//   in_op                  : OP_ADD (a+b+cin) or OP_SUB (a-b-bin)
//   in_a, in_b, in_cin     : operands and carry/borrow in
//   out_valid / out_ready  : output handshake
//   out_result             : sum or difference
//   out_cout/ovf/zero/neg  : carry|borrow out, signed overflow, zero, sign
// Build option: define PIPE_ADDSUB_SAT_EN to clamp signed overflow to the
// signed max/min instead of wrapping.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic          out_valid_q;
  logic [WIDTH-1:0] res_q, res_d;
  addsub_flags_t flags_q, flags_d;
  logic          advance;

  // The whole pipe moves in lockstep; it only freezes when a result is
  // waiting at the output and the consumer is not taking it.
  assign in_ready = out_ready | ~out_valid_q;
  assign advance  = in_ready;

  // Stage k consumes operand slice k. Operand bits still pending shrink by
  // one slice per stage, while resolved result bits grow by one slice, so
  // each stage boundary only registers what later stages still need.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned PEND = WIDTH - k * SW;

    logic [PEND-1:0]      a_s, b_s;
    logic                 c_s, v_s, op_s;
    logic [SW-1:0]        sum;
    logic                 co;
    logic [(k+1)*SW-1:0]  r_d;

    if (k == 0) begin : g_src
      // Subtract is a + ~b + ~bin, so b and the borrow are inverted up front.
      assign a_s  = in_a;
      assign b_s  = (in_op == OP_SUB) ? ~in_b : in_b;
      assign c_s  = (in_op == OP_SUB) ? ~in_cin : in_cin;
      assign v_s  = in_valid;
      assign op_s = in_op;
      assign r_d  = sum;
    end else begin : g_link
      assign a_s  = g_stg[k-1].g_reg.a_q;
      assign b_s  = g_stg[k-1].g_reg.b_q;
      assign c_s  = g_stg[k-1].g_reg.c_q;
      assign v_s  = g_stg[k-1].g_reg.v_q;
      assign op_s = g_stg[k-1].g_reg.op_q;
      assign r_d  = {sum, g_stg[k-1].g_reg.r_q};
    end

    addsub_slice #(.W(SW)) u_slice (
      .a_i (a_s[SW-1:0]),
      .b_i (b_s[SW-1:0]),
      .c_i (c_s),
      .s_o (sum),
      .c_o (co)
    );

    if (k < STAGES - 1) begin : g_reg
      logic [PEND-SW-1:0]  a_q, b_q;
      logic [(k+1)*SW-1:0] r_q;
      logic                c_q, v_q, op_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q  <= 1'b0;
          a_q  <= '0;
          b_q  <= '0;
          r_q  <= '0;
          c_q  <= 1'b0;
          op_q <= OP_ADD;
        end else if (advance) begin
          v_q  <= v_s;
          a_q  <= a_s[PEND-1:SW];
          b_q  <= b_s[PEND-1:SW];
          r_q  <= r_d;
          c_q  <= co;
          op_q <= op_s;
        end
      end
    end else begin : g_out
      // Last slice: a_s/b_s hold exactly the top slice here, so their MSBs
      // are the operand sign bits (b already inverted for subtract).
      always_comb begin
        res_d         = r_d;
        flags_d.cout  = (op_s == OP_SUB) ? ~co : co;
        flags_d.ovf   = (a_s[SW-1] == b_s[SW-1]) && (sum[SW-1] != a_s[SW-1]);
`ifdef PIPE_ADDSUB_SAT_EN
        if (flags_d.ovf) begin
          res_d = a_s[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags_d.zero  = (res_d == '0);
        flags_d.neg   = res_d[WIDTH-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          res_q       <= '0;
          flags_q     <= '0;
        end else if (advance) begin
          out_valid_q <= v_s;
          if (v_s) begin
            res_q   <= res_d;
            flags_q <= flags_d;
          end
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_cout   = flags_q.cout;
  assign out_ovf    = flags_q.ovf;
  assign out_zero   = flags_q.zero;
  assign out_neg    = flags_q.neg;

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..128).
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth = number of carry-chain slices (legal: 1..8, WIDTH % STAGES == 0).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: input handshake; a transfer occurs when both are high at a clk edge.
REQ-006 SHALL have port in_op  input  1  0 = add, 1 = subtract.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  operands (two's complement / unsigned agnostic).
REQ-008 SHALL have port in_cin  input  1  carry-in for add, borrow-in for subtract.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: output handshake.
REQ-010 SHALL have port out_result  output  WIDTH  sum or difference.
REQ-011 SHALL have ports out_cout, out_ovf, out_zero, out_neg  output  1 each: carry-out (add) / borrow-out (sub), signed overflow, result == 0, result MSB.

Function
REQ-012 SHALL compute add as a + b + cin; subtract as a + ~b + ~cin (i.e. a - b - bin), all in WIDTH+1 bits.
REQ-013 SHALL report out_cout for subtract as borrow: 1 iff unsigned a < b + bin.
REQ-014 SHALL set out_ovf when operand sign bits (b inverted for subtract) agree and the result sign differs.
REQ-015 SHALL split the chain into STAGES slices of WIDTH/STAGES bits; slice k resolves in stage k, the carry between slices is registered, and higher operand bits plus lower result bits are skewed/deskewed through registers.
REQ-016 SHALL have latency exactly STAGES cycles from accepted input to out_valid with no stall; throughput one op per cycle.
REQ-017 SHALL drive in_ready = out_ready OR NOT out_valid (combinational); whole pipeline advances only when in_ready is high.
REQ-018 SHALL hold out_result and all flags stable while out_valid && !out_ready.
REQ-019 SHALL propagate bubbles: a stage whose valid bit is 0 carries no op; out_valid is the last stage's valid bit.
REQ-020 SHALL compute out_zero/out_neg from the final (post-saturation, if enabled) result.
REQ-021 SHALL wrap results modulo 2^WIDTH when saturation is not compiled in.

Reset
REQ-022 SHALL clear all per-stage valid bits, out_valid, out_result, out_cout, out_ovf, out_zero, out_neg to 0 on rst_n low, asynchronously.
REQ-023 SHALL discard in-flight ops on reset mid-operation; no output appears from them after deassert.
REQ-024 SHALL keep in_ready high in reset (out_valid == 0).

Configuration
REQ-025 SHALL, with PIPE_ADDSUB_SAT_EN defined, clamp out_result to signed max (0x7FFF..F) on positive overflow and signed min (0x800..0) on negative overflow, out_ovf still reported.
REQ-026 SHALL, without PIPE_ADDSUB_SAT_EN, omit saturation logic entirely and wrap per REQ-021.

Structure
REQ-027 SHALL place op encoding constants (OP_ADD, OP_SUB) and a flags struct typedef in shared package addsub_pkg.
REQ-028 SHALL instantiate STAGES copies of sub-module addsub_slice (parametrised slice width, carry in, sum out, carry out, combinational).

Verification (WIDTH=32, STAGES=4)
REQ-029 SHALL test sub 5 - 3, bin=0 -> after 4 cycles result 2, cout 0, ovf 0, zero 0.
REQ-030 SHALL test sub 3 - 5, bin=0 -> result 0xFFFFFFFE, cout 1 (borrow), neg 1; add 0xFFFFFFFF + 1, cin=0 -> result 0, cout 1, zero 1.
REQ-031 SHALL test add 0x7FFFFFFF + 1 -> ovf 1; result 0x80000000 without macro, 0x7FFFFFFF with PIPE_ADDSUB_SAT_EN.
REQ-032 SHALL test 8 back-to-back ops with out_ready held low cycles 3-6 -> in_ready low while stalled, no op lost/duplicated, order preserved.
REQ-033 SHALL test rst_n pulsed low with 3 ops in flight -> out_valid 0 immediately, no stale output after release.
REQ-034 SHALL test random a/b/op/cin, 10k ops with random out_ready -> every result and flag matches reference model.
